// File: rtl/zle_xca_ctl.sv
// Sequencing controller for the zero run-length encoder datapath.
// Drives the datapath selects from flag f and runs the i/o valid-ready handshakes.
module zle_xca_ctl #(
  parameter int MAXRUN = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_valid,
  output logic       i_ready,
  output logic       o_valid,
  input  logic       o_ready,
  input  logic       flush,
  input  logic       f,
  output logic       sel_o_d,
  output logic [1:0] sel_cnt,
  output logic       sel_f,
  output logic       busy
);

  // state      | meaning
  // START      | no run open; zero opens a run, nonzero is emitted as literal
  // ZEROS      | run open; inspect next token (zero -> ZEROS_T, nonzero/flush -> emit run)
  // ZEROS_T    | zero held on i_d; f reports cnt==MAXRUN, extend or emit full run
  typedef enum logic [1:0] {
    ST_START   = 2'd0,
    ST_ZEROS   = 2'd1,
    ST_ZEROS_T = 2'd2
  } state_t;

  localparam logic [1:0] CNT_HOLD  = 2'd0;
  localparam logic [1:0] CNT_LOAD1 = 2'd1;
  localparam logic [1:0] CNT_CLEAR = 2'd2;
  localparam logic [1:0] CNT_INC   = 2'd3;

  // The terminal count is decoded in the datapath; a mismatch would silently corrupt runs.
  if (MAXRUN != 15) begin : g_maxrun_check
    $error("zle_xca_ctl: MAXRUN must equal the datapath terminal count of 15");
  end

  state_t     state_q, state_d;
  logic       i_ready_c;
  logic       o_valid_c;
  logic       sel_o_d_c;
  logic [1:0] sel_cnt_c;
  logic       sel_f_c;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_START;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_ready_c = 1'b0;
    o_valid_c = 1'b0;
    sel_o_d_c = 1'b0;
    sel_cnt_c = CNT_HOLD;
    sel_f_c   = 1'b0;

    case (state_q)
      ST_START: begin
        if (i_valid && f) begin
          i_ready_c = 1'b1;
          sel_cnt_c = CNT_LOAD1;
          state_d   = ST_ZEROS;
        end else if (i_valid) begin
          o_valid_c = 1'b1;
          i_ready_c = o_ready;
        end
      end

      ST_ZEROS: begin
        if (i_valid && f) begin
          state_d = ST_ZEROS_T;
        end else if (i_valid || flush) begin
          // The terminating nonzero stays on i_d and is emitted from START next.
          o_valid_c = 1'b1;
          sel_o_d_c = 1'b1;
          if (o_ready) begin
            sel_cnt_c = CNT_CLEAR;
            state_d   = ST_START;
          end
        end
      end

      ST_ZEROS_T: begin
        sel_f_c = 1'b1;
        if (i_valid && !f) begin
          i_ready_c = 1'b1;
          sel_cnt_c = CNT_INC;
          state_d   = ST_ZEROS;
        end else if (i_valid) begin
          // Full run: the held zero is left in place to open the next run.
          o_valid_c = 1'b1;
          sel_o_d_c = 1'b1;
          if (o_ready) begin
            sel_cnt_c = CNT_CLEAR;
            state_d   = ST_START;
          end
        end
      end

      default: begin
        state_d = ST_START;
      end
    endcase
  end

  assign i_ready = reset & i_ready_c;
  assign o_valid = reset & o_valid_c;
  assign sel_o_d = reset & sel_o_d_c;
  assign sel_cnt = reset ? sel_cnt_c : CNT_HOLD;
  assign sel_f   = reset & sel_f_c;
  assign busy    = reset & (state_q != ST_START);

endmodule
